// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE754 adder/subtractor, operands accepted over valid/ready, result 4 edges later.
// Optional FP_ADD_RNE_EN selects round-to-nearest-even; default build truncates toward zero and saturates on overflow.
module fp_add_seq #(
    parameter int NX = 8,
    parameter int NM = 23
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [NX+NM:0] A,
    input  logic [NX+NM:0] B,
    input  logic           SUB,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [NX+NM:0] XOUT
);
    localparam int W   = NX + NM + 1;
    localparam int MW  = NM + 4;
    localparam int SW  = NM + 5;
    localparam int EW  = NX + 2;
    localparam int LZW = $clog2(NM + 5);

    localparam logic [NX-1:0]        EXP_ONES  = {NX{1'b1}};
    localparam logic signed [EW-1:0] EXP_INF_S = $signed({2'b00, EXP_ONES});
    localparam logic signed [EW-1:0] ZERO_S    = {EW{1'b0}};
    localparam logic signed [EW-1:0] ONE_S     = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(NM-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        logic [LZW-1:0] cnt;
        cnt = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) begin
                cnt = LZW'(MW - 1 - i);
            end
        end
        return cnt;
    endfunction

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [W-1:0]          r_xout;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic                  r_sign;
    logic [NX-1:0]         r_exp;
    logic [MW-1:0]         r_ml;
    logic [MW-1:0]         r_ms;
    logic                  r_eff_sub;
    logic                  r_special;
    logic [W-1:0]          r_spec_val;
    logic [SW-1:0]         r_sum;
    logic [MW-1:0]         r_mn;
    logic signed [EW-1:0]  r_en;
    logic                  r_zero;
    logic                  r_norm_ph;

    logic [NX-1:0]         w_ea, w_eb, w_el, w_es, w_diff;
    logic [NM-1:0]         w_fa, w_fb;
    logic [NM:0]           w_ma, w_mb, w_ml_raw, w_ms_raw;
    logic                  w_a_ge, w_sl, w_ss;
    logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [MW-1:0]         w_ext, w_ms_al;
    logic [2*MW-1:0]       w_wide;
    logic                  w_spec;
    logic [W-1:0]          w_spec_val;
    logic [SW-1:0]         w_sum;
    logic [LZW-1:0]        w_lz;
    logic [MW-1:0]         w_mn;
    logic signed [EW-1:0]  w_en;
    logic                  w_inc;
    logic [NM+1:0]         w_mr;
    logic signed [EW-1:0]  w_ef;
    logic [NM-1:0]         w_frac;
    logic [W-1:0]          w_res;

    // Unpack; exponent zero (zero or denormal) carries no hidden bit and so reads as signed zero.
    assign w_ea     = r_a[W-2:NM];
    assign w_eb     = r_b[W-2:NM];
    assign w_fa     = r_a[NM-1:0];
    assign w_fb     = r_b[NM-1:0];
    assign w_a_zero = (w_ea == {NX{1'b0}});
    assign w_b_zero = (w_eb == {NX{1'b0}});
    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != {NM{1'b0}});
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != {NM{1'b0}});
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == {NM{1'b0}});
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == {NM{1'b0}});
    assign w_ma     = w_a_zero ? {(NM+1){1'b0}} : {1'b1, w_fa};
    assign w_mb     = w_b_zero ? {(NM+1){1'b0}} : {1'b1, w_fb};

    assign w_a_ge   = ({w_ea, w_ma} >= {w_eb, w_mb});
    assign w_sl     = w_a_ge ? r_a[W-1] : r_b[W-1];
    assign w_ss     = w_a_ge ? r_b[W-1] : r_a[W-1];
    assign w_el     = w_a_ge ? w_ea : w_eb;
    assign w_es     = w_a_ge ? w_eb : w_ea;
    assign w_ml_raw = w_a_ge ? w_ma : w_mb;
    assign w_ms_raw = w_a_ge ? w_mb : w_ma;
    assign w_diff   = w_el - w_es;
    assign w_ext    = {w_ms_raw, 3'b000};
    assign w_wide   = {w_ext, {MW{1'b0}}} >> w_diff;

    // Alignment shift: the lower half of the wide shift holds every bit pushed out, folded into sticky.
    always_comb begin
        w_ms_al = {MW{1'b0}};
        if (32'(w_diff) >= 32'(NM + 3)) begin
            w_ms_al = {{(MW-1){1'b0}}, |w_ms_raw};
        end else begin
            w_ms_al = w_wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |w_wide[MW-1:0]};
        end
    end

    // Special-case result selection; the flag bypasses the arithmetic result at the end.
    always_comb begin
        w_spec     = w_a_nan | w_b_nan | w_a_inf | w_b_inf | (w_a_zero & w_b_zero);
        w_spec_val = {W{1'b0}};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[W-1] != r_b[W-1]))) begin
            w_spec_val = QNAN;
        end else if (w_a_inf) begin
            w_spec_val = {r_a[W-1], EXP_ONES, {NM{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_val = {r_b[W-1], EXP_ONES, {NM{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_val = {r_a[W-1] & r_b[W-1], {(W-1){1'b0}}};
        end else begin
            w_spec_val = {W{1'b0}};
        end
    end

    // The larger magnitude sits in r_ml, so the effective subtraction never goes negative.
    assign w_sum = r_eff_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});

    // Normalisation: carry shifts right one place, otherwise a single-cycle left shift by the zero count.
    always_comb begin
        w_lz = lzc(r_sum[MW-1:0]);
        w_mn = {MW{1'b0}};
        w_en = ZERO_S;
        if (r_sum[SW-1]) begin
            w_mn = {r_sum[SW-1:2], r_sum[1] | r_sum[0]};
            w_en = $signed({2'b00, r_exp}) + ONE_S;
        end else begin
            w_mn = r_sum[MW-1:0] << w_lz;
            w_en = $signed({2'b00, r_exp}) - $signed({{(EW-LZW){1'b0}}, w_lz});
        end
    end

`ifdef FP_ADD_RNE_EN
    assign w_inc = r_mn[2] & (r_mn[1] | r_mn[0] | r_mn[3]);
`else
    assign w_inc = 1'b0 & (|r_mn[2:0]);
`endif

    assign w_mr   = {1'b0, r_mn[MW-1:3]} + {{(NM+1){1'b0}}, w_inc};
    assign w_ef   = r_en + $signed({{(EW-1){1'b0}}, w_mr[NM+1]});
    assign w_frac = w_mr[NM+1] ? w_mr[NM:1] : w_mr[NM-1:0];

    // Final packing: specials, exact zero, underflow flush, overflow, then the rounded value.
    always_comb begin
        w_res = {W{1'b0}};
        if (r_special) begin
            w_res = r_spec_val;
        end else if (r_zero) begin
            w_res = {W{1'b0}};
        end else if (r_en <= ZERO_S) begin
            w_res = {r_sign, {(W-1){1'b0}}};
        end else if (w_ef >= EXP_INF_S) begin
`ifdef FP_ADD_RNE_EN
            w_res = {r_sign, EXP_ONES, {NM{1'b0}}};
`else
            w_res = {r_sign, {(NX-1){1'b1}}, 1'b0, {NM{1'b1}}};
`endif
        end else begin
            w_res = {r_sign, w_ef[NX-1:0], w_frac};
        end
    end

    // Control FSM and all datapath registers; NORM spends one cycle normalising and one rounding.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_xout      <= {W{1'b0}};
            r_a         <= {W{1'b0}};
            r_b         <= {W{1'b0}};
            r_sign      <= 1'b0;
            r_exp       <= {NX{1'b0}};
            r_ml        <= {MW{1'b0}};
            r_ms        <= {MW{1'b0}};
            r_eff_sub   <= 1'b0;
            r_special   <= 1'b0;
            r_spec_val  <= {W{1'b0}};
            r_sum       <= {SW{1'b0}};
            r_mn        <= {MW{1'b0}};
            r_en        <= ZERO_S;
            r_zero      <= 1'b0;
            r_norm_ph   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID && r_in_ready) begin
                        r_a        <= A;
                        r_b        <= {B[W-1] ^ SUB, B[W-2:0]};
                        r_in_ready <= 1'b0;
                        r_state    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_sign     <= w_sl;
                    r_exp      <= w_el;
                    r_ml       <= {w_ml_raw, 3'b000};
                    r_ms       <= w_ms_al;
                    r_eff_sub  <= w_sl ^ w_ss;
                    r_special  <= w_spec;
                    r_spec_val <= w_spec_val;
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    r_sum     <= w_sum;
                    r_norm_ph <= 1'b0;
                    r_state   <= S_NORM;
                end
                S_NORM: begin
                    if (!r_norm_ph) begin
                        r_mn      <= w_mn;
                        r_en      <= w_en;
                        r_zero    <= (r_sum == {SW{1'b0}});
                        r_norm_ph <= 1'b1;
                    end else begin
                        r_xout      <= w_res;
                        r_out_valid <= 1'b1;
                        r_norm_ph   <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_norm_ph   <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign XOUT      = r_xout;

endmodule
